// File: rtl/fwd_hazard_unit_if.sv
// fwd_hazard_unit_if: ID-stage decode/control into the hazard unit and its forward/stall results.
interface fwd_hazard_unit_if #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 3,
    parameter int CNT_W  = 16
);
    localparam int SEL_W = $clog2(DEPTH);

    logic              id_valid;
    logic [ADDR_W-1:0] id_rs;
    logic [ADDR_W-1:0] id_rt;
    logic              id_rs_used;
    logic              id_rt_used;
    logic [ADDR_W-1:0] id_rd;
    logic              id_reg_write;
    logic              id_is_load;
    logic              flush;
    logic              hold;
    logic [SEL_W-1:0]  fwd_a;
    logic [SEL_W-1:0]  fwd_b;
    logic              stall;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd, id_reg_write, id_is_load,
        output flush, hold,
        input  fwd_a, fwd_b, stall, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd, id_reg_write, id_is_load,
        input  flush, hold,
        output fwd_a, fwd_b, stall, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: tag pipeline of in-flight instructions from EX onward, driving EX operand
// forward selects and a load-use stall for ID.
module fwd_hazard_unit #(
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2,
    parameter int CNT_W      = 16
) (
    input logic clk,
    input logic reset,
    fwd_hazard_unit_if.slave bus
);
    localparam int SEL_W = $clog2(DEPTH);

    logic [DEPTH-1:0]  v, wr, ld;
    logic [ADDR_W-1:0] rd [DEPTH];
    logic [ADDR_W-1:0] rs, rt;
    logic              rs_used, rt_used;
    logic [DEPTH-1:0]  w, ea, eb, ia, ib;
    logic [SEL_W-1:0]  fa, fb;
    logic              sa, sb, stall;
    logic [CNT_W-1:0]  cnt;

    // ea/eb compare against the EX instruction's sources, ia/ib against the ID sources
    for (genvar j = 0; j < DEPTH; j++) begin : g_match
        assign w[j]  = v[j] && wr[j] && rd[j] != '0;
        assign ea[j] = w[j] && rd[j] == rs;
        assign eb[j] = w[j] && rd[j] == rt;
        assign ia[j] = w[j] && rd[j] == bus.id_rs;
        assign ib[j] = w[j] && rd[j] == bus.id_rt;
    end

    always_comb begin
        fa = '0;
        fb = '0;
        for (int j = DEPTH - 1; j >= 1; j--) begin
            if (ea[j]) fa = (!ld[j] || j >= LOAD_READY) ? SEL_W'(j) : '0;
            if (eb[j]) fb = (!ld[j] || j >= LOAD_READY) ? SEL_W'(j) : '0;
        end
        fa = (v[0] && rs_used) ? fa : '0;
        fb = (v[0] && rt_used) ? fb : '0;
    end

    always_comb begin
        sa = 1'b0;
        sb = 1'b0;
        for (int j = DEPTH - 1; j >= 0; j--) begin
            if (ia[j]) sa = ld[j] && (j + 1 < LOAD_READY);
            if (ib[j]) sb = ld[j] && (j + 1 < LOAD_READY);
        end
    end

    assign stall = !reset && bus.id_valid && !bus.flush &&
                   ((bus.id_rs_used && sa) || (bus.id_rt_used && sb));

    always_ff @(posedge clk) begin
        if (reset) begin
            v   <= '0;
            cnt <= '0;
        end else if (!bus.hold) begin
            v       <= {v[DEPTH-2:0], bus.id_valid && !stall && !bus.flush};
            wr      <= {wr[DEPTH-2:0], bus.id_reg_write};
            ld      <= {ld[DEPTH-2:0], bus.id_is_load};
            rd[0]   <= bus.id_rd;
            for (int k = 1; k < DEPTH; k++) rd[k] <= rd[k-1];
            rs      <= bus.id_rs;
            rt      <= bus.id_rt;
            rs_used <= bus.id_rs_used;
            rt_used <= bus.id_rt_used;
            if (stall && cnt != '1) cnt <= cnt + 1'b1;
        end
    end

    assign bus.fwd_a     = fa;
    assign bus.fwd_b     = fb;
    assign bus.stall     = stall;
    assign bus.stall_cnt = cnt;
endmodule
